ifetch_queue: RTL and testbench

Decoupled instruction-fetch stage that sits between the instruction ROM and decode_module, replacing the single-register fetch. It issues in-order requests to a variable-latency instruction memory and buffers returned instructions with their PCs in a small FIFO. Decode pops the head through the existing 18-bit brbus. Taken branches flush the queue and drop stale in-flight responses.

---
 rtl/ifetch_queue_pkg.sv | 28 ++
 rtl/ifetch_queue_fifo.sv | 62 ++++++
 rtl/ifetch_queue.sv | 109 ++++++++++
 tb/tb_ifetch_queue.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the decoupled instruction-fetch queue:
// brbus field layout, PC/address geometry and the queue entry format.
package ifetch_queue_pkg;

    // brbus layout: {pop, taken, signed byte offset}
    localparam int BR_VALID   = 17;
    localparam int BR_TAKEN   = 16;
    localparam int BR_OFF_MSB = 15;
    localparam int BR_OFF_LSB = 0;

    localparam int PC_W    = 16;
    localparam int IMEM_AW = 12;

    localparam logic [PC_W-1:0] NOP_INST = 16'h0000;
    localparam logic [PC_W-1:0] PC_INC   = 16'd2;

    // One queued instruction tagged with the PC it was fetched from
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] inst;
    } ifq_entry_t;

    // Sequential PC step; wraps naturally at 2^16
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Small synchronous FIFO of {pc, inst} entries. A flush empties the queue
// and wins over any push or pop in the same cycle. Push on a full queue is
// accepted only when a pop frees a slot in that same cycle.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  ifq_entry_t               din,
    output logic                     full,
    output logic                     empty,
    output ifq_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Entry storage: data only, never reset
    always_ff @(posedge clock) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction fetch: issues in-order requests to a variable-latency
// instruction memory, queues returned instructions with their PCs, and hands
// the head to decode over brbus. A taken branch flushes the queue and marks
// every still-in-flight response for silent discard.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [15:0] RESET_PC  = 16'h0000
)(
    input  logic         clock,
    input  logic         reset,
    input  logic [17:0]  brbus,
    output logic         imem_req,
    output logic [11:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [15:0]  imem_rdata,
    output logic [15:0]  inst,
    output logic [15:0]  inst_pc,
    output logic         inst_valid
);

    localparam int QW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTST) + 1;
    localparam int SW = QW + 1;

    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_tail_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_discard;

    logic            w_full;
    logic            w_empty;
    ifq_entry_t      w_head;
    ifq_entry_t      w_din;
    logic [QW-1:0]   w_count;
    logic            w_valid;
    logic            w_pop;
    logic            w_redirect;
    logic            w_accept;
    logic            w_resp;
    logic            w_push;
    logic            w_room;
    logic [SW-1:0]   w_credit;
    logic [PC_W-1:0] w_target;

    // Head is only presented outside reset so decode never sees stale entries
    assign w_valid    = ~w_empty & ~reset;
    assign w_pop      = brbus[BR_VALID] & w_valid;
    assign w_redirect = w_pop & brbus[BR_TAKEN];
    assign w_target   = w_head.pc + brbus[BR_OFF_MSB:BR_OFF_LSB];

    // Every in-flight request already owns a queue slot, so a response can
    // always be pushed
    assign w_credit = SW'(w_count) + SW'(r_outst);
    assign w_room   = ~w_full & (w_credit < SW'(DEPTH));
    assign imem_req = ~reset & ~w_redirect & w_room & (r_outst < OW'(MAX_OUTST));
    assign imem_addr = r_fetch_pc[IMEM_AW-1:0];

    assign w_accept = imem_req & imem_ready;
    assign w_resp   = imem_rvalid & (r_outst != '0);
    assign w_push   = w_resp & (r_discard == '0);

    assign w_din.pc   = r_tail_pc;
    assign w_din.inst = imem_rdata;

    assign inst       = w_valid ? w_head.inst : NOP_INST;
    assign inst_pc    = w_valid ? w_head.pc   : '0;
    assign inst_valid = w_valid;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_redirect),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head),
        .count (w_count)
    );

    // Fetch/tail PCs and in-flight request bookkeeping
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_tail_pc  <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
        end else if (w_redirect) begin
            // No request issues this cycle; all survivors in flight are stale
            r_fetch_pc <= w_target;
            r_tail_pc  <= w_target;
            r_outst    <= r_outst - OW'(w_resp);
            r_discard  <= r_outst - OW'(w_resp);
        end else begin
            if (w_accept) r_fetch_pc <= pc_next(r_fetch_pc);
            if (w_push)   r_tail_pc  <= pc_next(r_tail_pc);
            r_outst <= r_outst + OW'(w_accept) - OW'(w_resp);
            if (w_resp && (r_discard != '0)) r_discard <= r_discard - OW'(1);
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: an in-order variable-latency memory and
// a queue-based reference model of the fetch stream.
module tb_ifetch_queue;

    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [17:0] brbus;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;

    logic [17:0] brbus2;
    logic        req2;
    logic [11:0] addr2;
    logic        ready2;
    logic        rvalid2;
    logic [15:0] rdata2;
    logic [15:0] inst2;
    logic [15:0] inst_pc2;
    logic        valid2;

    always #5 clock = ~clock;

    ifetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .brbus(brbus),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
    );

    ifetch_queue #(.DEPTH(4), .MAX_OUTST(2), .RESET_PC(16'hFFFC)) dut_wrap (
        .clock(clock), .reset(reset), .brbus(brbus2),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(ready2),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .inst(inst2), .inst_pc(inst_pc2), .inst_valid(valid2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: queued PCs in order, next fetch/tail PCs, in-flight count
    logic [15:0] m_q[$];
    logic [15:0] m_fetch;
    logic [15:0] m_tail;
    int          m_out;
    int          m_disc;

    // Memory: accepted addresses with their acceptance cycle
    logic [11:0] mem_addr_q[$];
    int          mem_cyc_q[$];
    int          mem_lat = 1;
    int          mem_pct = 100;

    logic        obs_valid, obs_req, exp_valid, exp_req;
    logic [15:0] obs_pc, obs_inst, exp_pc, exp_inst;
    logic [11:0] obs_addr, exp_addr;

    function automatic logic [15:0] memdata(input logic [11:0] a);
        return {a[3:0], a} ^ 16'h3C5A;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fetch = RESET_PC;
        m_tail  = RESET_PC;
        m_out   = 0;
        m_disc  = 0;
        mem_addr_q.delete();
        mem_cyc_q.delete();
        cyc = 0;
    endtask

    task automatic idle_inputs();
        brbus = '0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        brbus2 = '0; ready2 = 1'b0; rvalid2 = 1'b0; rdata2 = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock of stimulus: drives inputs, snapshots DUT and model
    // expectations at the falling edge, then advances the model.
    task automatic step(input bit pop, input bit taken, input logic [15:0] off, input bit ready);
        bit          rv;
        bit          red;
        bit          acc;
        logic [15:0] tgt;
        rv = 1'b0;
        imem_rdata = '0;
        if (mem_addr_q.size() > 0) begin
            if (cyc >= mem_cyc_q[0] + mem_lat && $urandom_range(99) < mem_pct) begin
                rv = 1'b1;
                imem_rdata = memdata(mem_addr_q[0]);
                void'(mem_addr_q.pop_front());
                void'(mem_cyc_q.pop_front());
            end
        end
        imem_rvalid = rv;
        brbus       = {pop, taken, off};
        imem_ready  = ready;

        exp_valid = (m_q.size() > 0);
        exp_pc    = exp_valid ? m_q[0] : 16'h0000;
        exp_inst  = exp_valid ? memdata(exp_pc[11:0]) : 16'h0000;
        red       = pop && taken && exp_valid;
        exp_req   = !red && (m_q.size() + m_out < DEPTH) && (m_out < MAX_OUTST);
        exp_addr  = m_fetch[11:0];

        @(negedge clock);
        obs_valid = inst_valid;
        obs_req   = imem_req;
        obs_pc    = inst_pc;
        obs_inst  = inst;
        obs_addr  = imem_addr;
        if (obs_req && ready) begin
            mem_addr_q.push_back(imem_addr);
            mem_cyc_q.push_back(cyc);
        end

        acc = exp_req && ready;
        if (rv && m_out == 0) rv = 1'b0;
        if (red) begin
            tgt = m_q[0] + off;
            m_q.delete();
            m_fetch = tgt;
            m_tail  = tgt;
            if (rv) m_out--;
            m_disc = m_out;
        end else begin
            if (pop && exp_valid) void'(m_q.pop_front());
            if (rv) begin
                if (m_disc > 0) m_disc--;
                else begin
                    m_q.push_back(m_tail);
                    m_tail = m_tail + 16'd2;
                end
            end
            if (acc) m_fetch = m_fetch + 16'd2;
            m_out = m_out + int'(acc) - int'(rv);
        end
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        n_checks++;
        if ({imem_req, inst_valid, inst, inst_pc} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_during: req=%b v=%b inst=%h pc=%h, want all zero", imem_req, inst_valid, inst, inst_pc);
        end
        @(posedge clock); #1;
        n_checks++;
        if ({inst_valid, inst, inst_pc, imem_addr} !== {1'b0, 16'h0, 16'h0, RESET_PC[11:0]}) begin
            n_fail++;
            $display("FAIL reset_after: v=%b inst=%h pc=%h addr=%h, want 0/0/0/%h", inst_valid, inst, inst_pc, imem_addr, RESET_PC[11:0]);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        mem_lat = 1; mem_pct = 100;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1);
            n_checks++;
            if ({obs_valid, obs_req, obs_pc, obs_inst, obs_addr} !== {exp_valid, exp_req, exp_pc, exp_inst, exp_addr}) begin
                n_fail++;
                $display("FAIL b2b_model cyc=%0d: got v%b r%b pc%h i%h a%h, want v%b r%b pc%h i%h a%h", k,
                         obs_valid, obs_req, obs_pc, obs_inst, obs_addr, exp_valid, exp_req, exp_pc, exp_inst, exp_addr);
            end
            if (k >= 2) begin
                n_checks++;
                if (!(obs_valid === 1'b1 && obs_pc === 16'(2 * (k - 2)))) begin
                    n_fail++;
                    $display("FAIL b2b_stream cyc=%0d: v=%b pc=%h, want v=1 pc=%h", k, obs_valid, obs_pc, 16'(2 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_no_pop();
        int max_out;
        apply_reset();
        mem_lat = 1; mem_pct = 100;
        max_out = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            if (mem_addr_q.size() > max_out) max_out = mem_addr_q.size();
            n_checks++;
            if ({obs_valid, obs_req, obs_pc, obs_inst, obs_addr} !== {exp_valid, exp_req, exp_pc, exp_inst, exp_addr}) begin
                n_fail++;
                $display("FAIL nopop_model cyc=%0d: got v%b r%b pc%h i%h a%h, want v%b r%b pc%h i%h a%h", k,
                         obs_valid, obs_req, obs_pc, obs_inst, obs_addr, exp_valid, exp_req, exp_pc, exp_inst, exp_addr);
            end
        end
        n_checks++;
        if (!(obs_req === 1'b0 && obs_valid === 1'b1 && obs_pc === 16'h0000 && obs_addr === 12'h008 && max_out <= MAX_OUTST)) begin
            n_fail++;
            $display("FAIL nopop_saturate: req=%b v=%b pc=%h addr=%h maxout=%0d, want 0/1/0000/008/<=%0d",
                     obs_req, obs_valid, obs_pc, obs_addr, max_out, MAX_OUTST);
        end
    endtask

    task automatic test_redirect();
        bit fired;
        bit seen;
        apply_reset();
        mem_lat = 3; mem_pct = 100;
        fired = 1'b0;
        for (int k = 0; k < 200 && !fired; k++) begin
            if (m_q.size() > 0 && m_q[0] == 16'h0008 && m_out == 2) begin
                step(1'b1, 1'b1, 16'hFFF8, 1'b1);
                fired = 1'b1;
            end else begin
                step(m_q.size() > 0 && m_q[0] < 16'h0008, 1'b0, 16'h0, 1'b1);
            end
            n_checks++;
            if ({obs_valid, obs_req, obs_pc, obs_inst, obs_addr} !== {exp_valid, exp_req, exp_pc, exp_inst, exp_addr}) begin
                n_fail++;
                $display("FAIL redir_model cyc=%0d: got v%b r%b pc%h i%h a%h, want v%b r%b pc%h i%h a%h", k,
                         obs_valid, obs_req, obs_pc, obs_inst, obs_addr, exp_valid, exp_req, exp_pc, exp_inst, exp_addr);
            end
        end
        n_checks++;
        if (!fired) begin
            n_fail++;
            $display("FAIL redir_setup: head 0008 with 2 outstanding never reached, want reached");
        end
        seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b0, 16'h0, 1'b1);
            n_checks++;
            if ({obs_valid, obs_req, obs_pc, obs_inst, obs_addr} !== {exp_valid, exp_req, exp_pc, exp_inst, exp_addr}) begin
                n_fail++;
                $display("FAIL redir_after cyc=%0d: got v%b r%b pc%h i%h a%h, want v%b r%b pc%h i%h a%h", k,
                         obs_valid, obs_req, obs_pc, obs_inst, obs_addr, exp_valid, exp_req, exp_pc, exp_inst, exp_addr);
            end
            if (k == 0) begin
                n_checks++;
                if (obs_addr !== 12'h000 || obs_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL redir_target: addr=%h v=%b, want 000/0", obs_addr, obs_valid);
                end
            end
            if (obs_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                n_checks++;
                if (obs_pc !== 16'h0000 || obs_inst !== memdata(12'h000)) begin
                    n_fail++;
                    $display("FAIL redir_first: pc=%h inst=%h, want 0000/%h", obs_pc, obs_inst, memdata(12'h000));
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL redir_timeout: target instruction never became valid");
        end
    endtask

    task automatic test_stall();
        logic [11:0] held;
        logic [15:0] next_pc;
        apply_reset();
        mem_lat = 1; mem_pct = 100;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 16'h0, 1'b1);
        held = m_fetch[11:0];
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (obs_req !== 1'b1 || obs_addr !== held || exp_addr !== held) begin
                n_fail++;
                $display("FAIL stall_hold k=%0d: req=%b addr=%h, want 1/%h", k, obs_req, obs_addr, held);
            end
        end
        next_pc = {4'h0, held};
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1);
            n_checks++;
            if ({obs_valid, obs_req, obs_pc, obs_inst, obs_addr} !== {exp_valid, exp_req, exp_pc, exp_inst, exp_addr}) begin
                n_fail++;
                $display("FAIL stall_model k=%0d: got v%b r%b pc%h i%h a%h, want v%b r%b pc%h i%h a%h", k,
                         obs_valid, obs_req, obs_pc, obs_inst, obs_addr, exp_valid, exp_req, exp_pc, exp_inst, exp_addr);
            end
            if (obs_valid === 1'b1) begin
                n_checks++;
                if (obs_pc !== next_pc) begin
                    n_fail++;
                    $display("FAIL stall_seq k=%0d: pc=%h, want %h", k, obs_pc, next_pc);
                end
                next_pc = next_pc + 16'd2;
            end
        end
    endtask

    task automatic test_random();
        bit          pop;
        bit          taken;
        logic [15:0] off;
        apply_reset();
        for (int k = 0; k < 800; k++) begin
            if (k % 100 == 0) begin
                mem_lat = $urandom_range(1, 3);
                mem_pct = $urandom_range(40, 100);
            end
            pop   = ($urandom_range(99) < 70);
            taken = ($urandom_range(99) < 10);
            if ($urandom_range(9) == 0) off = 16'hFFF0 - 16'(2 * $urandom_range(0, 7));
            else off = 16'(2 * $urandom_range(0, 31)) - 16'd32;
            step(pop, taken, off, $urandom_range(99) < 75);
            n_checks++;
            if ({obs_valid, obs_req, obs_pc, obs_inst, obs_addr} !== {exp_valid, exp_req, exp_pc, exp_inst, exp_addr}) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got v%b r%b pc%h i%h a%h, want v%b r%b pc%h i%h a%h", k,
                         obs_valid, obs_req, obs_pc, obs_inst, obs_addr, exp_valid, exp_req, exp_pc, exp_inst, exp_addr);
            end
        end
    endtask

    task automatic test_midreset();
        bit seen;
        apply_reset();
        mem_lat = 1; mem_pct = 100;
        for (int k = 0; k < 30 && m_q.size() < DEPTH; k++) step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL midrst_full: v=%b pc=%h, want 1/0000", obs_valid, obs_pc);
        end
        reset = 1'b1;
        idle_inputs();
        brbus = {1'b1, 1'b1, 16'h0040};
        imem_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({imem_req, inst_valid, inst, inst_pc} !== {1'b0, 1'b0, 16'h0, 16'h0}) begin
            n_fail++;
            $display("FAIL midrst_during: req=%b v=%b inst=%h pc=%h, want all zero", imem_req, inst_valid, inst, inst_pc);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(m_q.size() == 0, 1'b1, 16'h0100, 1'b1);
            n_checks++;
            if ({obs_valid, obs_req, obs_pc, obs_inst, obs_addr} !== {exp_valid, exp_req, exp_pc, exp_inst, exp_addr}) begin
                n_fail++;
                $display("FAIL midrst_model cyc=%0d: got v%b r%b pc%h i%h a%h, want v%b r%b pc%h i%h a%h", k,
                         obs_valid, obs_req, obs_pc, obs_inst, obs_addr, exp_valid, exp_req, exp_pc, exp_inst, exp_addr);
            end
            if (k == 0) begin
                n_checks++;
                if (obs_valid !== 1'b0 || obs_inst !== 16'h0 || obs_addr !== RESET_PC[11:0]) begin
                    n_fail++;
                    $display("FAIL midrst_after: v=%b inst=%h addr=%h, want 0/0000/%h", obs_valid, obs_inst, obs_addr, RESET_PC[11:0]);
                end
            end
            if (obs_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                n_checks++;
                if (obs_pc !== RESET_PC) begin
                    n_fail++;
                    $display("FAIL midrst_restart: pc=%h, want %h", obs_pc, RESET_PC);
                end
            end
        end
    endtask

    task automatic test_reset_pc_wrap();
        bit          pend;
        logic [11:0] pend_addr;
        logic [15:0] exp;
        apply_reset();
        pend = 1'b0;
        pend_addr = '0;
        ready2 = 1'b1;
        brbus2 = {1'b1, 1'b0, 16'h0000};
        for (int k = 0; k < 7; k++) begin
            rvalid2 = pend;
            rdata2  = pend ? memdata(pend_addr) : 16'h0000;
            @(negedge clock);
            if (k >= 2 && k <= 5) begin
                exp = 16'hFFFC + 16'(2 * (k - 2));
                n_checks++;
                if (valid2 !== 1'b1 || inst_pc2 !== exp || inst2 !== memdata(exp[11:0])) begin
                    n_fail++;
                    $display("FAIL wrap k=%0d: v=%b pc=%h inst=%h, want 1/%h/%h", k, valid2, inst_pc2, inst2, exp, memdata(exp[11:0]));
                end
            end
            pend      = req2 & ready2;
            pend_addr = addr2;
            @(posedge clock); #1;
        end
        ready2 = 1'b0; rvalid2 = 1'b0; brbus2 = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_no_pop();
        test_redirect();
        test_stall();
        test_random();
        test_midreset();
        test_reset_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
